// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Serialises word requests, bounds-checks addresses and routes read data back to the issuer.
module dmem_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MEM_DEPTH = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              err0,
   output logic              err1,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state;
   logic   owner;
   logic   rr_last;
   logic   we_q;
   logic   oor_q;

   logic              winner;
   logic              sel_we;
   logic              sel_oor;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) winner = ~rr_last;
      else if (req1)    winner = 1'b1;
      sel_we    = winner ? we1    : we0;
      sel_addr  = winner ? addr1  : addr0;
      sel_wdata = winner ? wdata1 : wdata0;
      sel_oor   = (sel_addr >= ADDR_W'(MEM_DEPTH));
   end

   // NOTE: state and registered outputs use non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         rr_last   <= 1'b1;
         we_q      <= 1'b0;
         oor_q     <= 1'b0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         // Pulse outputs default low; each state raises only what it needs.
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner     <= winner;
                  rr_last   <= winner;
                  gnt0      <= ~winner;
                  gnt1      <= winner;
                  err0      <= ~winner & sel_oor;
                  err1      <= winner & sel_oor;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  we_q      <= sel_we;
                  oor_q     <= sel_oor;
                  mem_write <= sel_we & ~sel_oor;
                  mem_read  <= ~sel_we & ~sel_oor;
                  state     <= ACCESS;
               end
            end
            ACCESS: state <= we_q ? IDLE : RESP;
            RESP: begin
               // Out-of-range reads never touched memory, so they return zero.
               if (owner) begin
                  rdata1  <= oor_q ? '0 : mem_rdata;
                  rvalid1 <= 1'b1;
               end else begin
                  rdata0  <= oor_q ? '0 : mem_rdata;
                  rvalid0 <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
